// File: rtl/ucsbece154b_hazard_unit_p.sv
// Hazard/stall controller for the 5-stage pipeline with I/D caches:
// stalls, freezes, flushes, EX forwarding selects and a fetch-stall counter.
module ucsbece154b_hazard_unit_p #(
  parameter int unsigned RA_W        = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned RESUME_HOLD = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs1_d_i,
  input  logic [RA_W-1:0]  rs2_d_i,
  input  logic [RA_W-1:0]  rs1_e_i,
  input  logic [RA_W-1:0]  rs2_e_i,
  input  logic [RA_W-1:0]  rd_e_i,
  input  logic [RA_W-1:0]  rd_m_i,
  input  logic [RA_W-1:0]  rd_w_i,
  input  logic             regwrite_e_i,
  input  logic             regwrite_m_i,
  input  logic             regwrite_w_i,
  input  logic             load_e_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  input  logic             mispredict_e_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic [1:0]       fwd_a_e_o,
  output logic [1:0]       fwd_b_e_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(RESUME_HOLD);

  logic [2:0]       lu_cnt;
  logic [3:0]       hold_cnt;
  logic             miss_q;
  logic [CNT_W-1:0] stall_cycles;

  logic       freeze;
  logic       imiss;
  logic       lu_detect;
  logic       lu_stall;
  logic       raw_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Source matches a producing stage: non-zero, same register, stage writes back.
  function automatic logic src_hit(input logic [RA_W-1:0] rs,
                                   input logic [RA_W-1:0] rd,
                                   input logic            we);
    return we && (rs != '0) && (rs == rd);
  endfunction

  // Hazard detection terms and forwarding selects (M has priority over W).
  always_comb begin
    freeze    = ~dmem_ready_i | (hold_cnt != '0);
    imiss     = ~imem_ready_i;
    lu_detect = FWD_EN && load_e_i && (rd_e_i != '0) &&
                ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
    lu_stall  = lu_detect | (lu_cnt != '0);
    raw_stall = !FWD_EN && (src_hit(rs1_d_i, rd_e_i, regwrite_e_i) ||
                            src_hit(rs2_d_i, rd_e_i, regwrite_e_i) ||
                            src_hit(rs1_d_i, rd_m_i, regwrite_m_i) ||
                            src_hit(rs2_d_i, rd_m_i, regwrite_m_i));
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      if (src_hit(rs1_e_i, rd_m_i, regwrite_m_i))      fwd_a = 2'b10;
      else if (src_hit(rs1_e_i, rd_w_i, regwrite_w_i)) fwd_a = 2'b01;
      if (src_hit(rs2_e_i, rd_m_i, regwrite_m_i))      fwd_b = 2'b10;
      else if (src_hit(rs2_e_i, rd_w_i, regwrite_w_i)) fwd_b = 2'b01;
    end
  end

  // Pipeline control outputs: reset > freeze > mispredict > I-miss/load-use/RAW.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    fwd_a_e_o = 2'b00;
    fwd_b_e_o = 2'b00;
    if (reset) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else begin
      fwd_a_e_o = fwd_a;
      fwd_b_e_o = fwd_b;
      if (freeze) begin
        stall_f_o = 1'b1;
        stall_d_o = 1'b1;
        stall_e_o = 1'b1;
      end else if (mispredict_e_i) begin
        flush_d_o = 1'b1;
        flush_e_o = 1'b1;
        stall_f_o = imiss;
      end else begin
        stall_f_o = imiss | lu_stall | raw_stall;
        stall_d_o = imiss | lu_stall | raw_stall;
        flush_e_o = imiss | lu_stall | raw_stall;
      end
    end
  end

  // Load-use bubble counter; frozen during freeze, cleared by a mispredict.
  always_ff @(posedge clk) begin
    if (reset)                              lu_cnt <= '0;
    else if (freeze)                        lu_cnt <= lu_cnt;
    else if (mispredict_e_i)                lu_cnt <= '0;
    else if (lu_detect && (lu_cnt == '0))   lu_cnt <= LU_RELOAD;
    else if (lu_cnt != '0)                  lu_cnt <= lu_cnt - 3'd1;
  end

  // Cache-miss tracker and post-miss whole-pipe hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_q   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      miss_q <= ~imem_ready_i | ~dmem_ready_i;
      if (miss_q && imem_ready_i && dmem_ready_i) hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0)                    hold_cnt <= hold_cnt - 4'd1;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk) begin
    if (reset)                                   stall_cycles <= '0;
    else if (stall_f_o && (stall_cycles != '1))  stall_cycles <= stall_cycles + CNT_W'(1);
  end

  assign stall_cycles_o = stall_cycles;

endmodule

// File: tb/tb_ucsbece154b_hazard_unit_p.sv
// Scoreboard bench for ucsbece154b_hazard_unit_p: two configurations share stimulus.
module tb_ucsbece154b_hazard_unit_p;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_e, regwrite_m, regwrite_w, load_e;
  logic       imem_ready, dmem_ready, mispredict;

  logic        sf_a, sd_a, se_a, fd_a, fe_a;
  logic [1:0]  fwa_a, fwb_a;
  logic [3:0]  cnt_a;
  logic        sf_b, sd_b, se_b, fd_b, fe_b;
  logic [1:0]  fwa_b, fwb_b;
  logic [31:0] cnt_b;

  // A: forwarding, 2-cycle load-use, 1-cycle resume hold, 4-bit counter
  ucsbece154b_hazard_unit_p #(.RA_W(5), .LOAD_LAT(2), .FWD_EN(1'b1), .RESUME_HOLD(1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
    .rd_e_i(rd_e), .rd_m_i(rd_m), .rd_w_i(rd_w),
    .regwrite_e_i(regwrite_e), .regwrite_m_i(regwrite_m), .regwrite_w_i(regwrite_w),
    .load_e_i(load_e), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .mispredict_e_i(mispredict),
    .stall_f_o(sf_a), .stall_d_o(sd_a), .stall_e_o(se_a), .flush_d_o(fd_a), .flush_e_o(fe_a),
    .fwd_a_e_o(fwa_a), .fwd_b_e_o(fwb_a), .stall_cycles_o(cnt_a)
  );

  // B: no forwarding, no resume hold, default counter width
  ucsbece154b_hazard_unit_p #(.RA_W(5), .LOAD_LAT(1), .FWD_EN(1'b0), .RESUME_HOLD(0), .CNT_W(32)) u_b (
    .clk(clk), .reset(reset),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
    .rd_e_i(rd_e), .rd_m_i(rd_m), .rd_w_i(rd_w),
    .regwrite_e_i(regwrite_e), .regwrite_m_i(regwrite_m), .regwrite_w_i(regwrite_w),
    .load_e_i(load_e), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .mispredict_e_i(mispredict),
    .stall_f_o(sf_b), .stall_d_o(sd_b), .stall_e_o(se_b), .flush_d_o(fd_b), .flush_e_o(fe_b),
    .fwd_a_e_o(fwa_b), .fwd_b_e_o(fwb_b), .stall_cycles_o(cnt_b)
  );

  // Expected A control vector: {stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a, fwd_b}
  localparam logic [8:0] IDLE  = 9'b000_00_00_00;
  localparam logic [8:0] RST   = 9'b000_11_00_00;
  localparam logic [8:0] STL   = 9'b110_01_00_00;
  localparam logic [8:0] FRZ   = 9'b111_00_00_00;
  localparam logic [8:0] MSP   = 9'b000_11_00_00;
  localparam logic [8:0] MSPI  = 9'b100_11_00_00;
  localparam logic [8:0] FWA_M = 9'b000_00_10_00;
  localparam logic [8:0] FWB_W = 9'b000_00_00_01;

  // cnt < 0 skips the A counter check; b < 0 skips the B {stall_f, fwd_a} check
  typedef struct {
    string      nm;
    logic [8:0] a;
    int         cnt;
    int         b;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] act;
    logic [2:0] act_b;
    if (q.size() != 0) begin
      e     = q.pop_front();
      act   = {sf_a, sd_a, se_a, fd_a, fe_a, fwa_a, fwb_a};
      act_b = {sf_b, fwa_b};
      tests++;
      if (act !== e.a) begin
        fails++;
        $display("FAIL %s ctrl_a: got %b want %b", e.nm, act, e.a);
      end
      if (e.cnt >= 0) begin
        tests++;
        if (cnt_a !== 4'(e.cnt)) begin
          fails++;
          $display("FAIL %s cnt_a: got %0d want %0d", e.nm, cnt_a, e.cnt);
        end
      end
      if (e.b >= 0) begin
        tests++;
        if (act_b !== 3'(e.b)) begin
          fails++;
          $display("FAIL %s ctrl_b: got %b want %b", e.nm, act_b, 3'(e.b));
        end
      end
    end
  end

  task automatic idle();
    reset      = 1'b0;
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e  = '0; rd_m  = '0; rd_w  = '0;
    regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    load_e     = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    mispredict = 1'b0;
  endtask

  // Push the expectation for the inputs currently applied, then advance one cycle.
  task automatic cyc(input string nm, input logic [8:0] a, input int cnt, input int b);
    exp_t e;
    e.nm = nm; e.a = a; e.cnt = cnt; e.b = b;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst", RST, 0, 0);

    // I-miss from reset, then one resume-hold freeze cycle
    idle(); imem_ready = 1'b0;
    cyc("imiss0", STL, 0, 4);
    cyc("imiss1", STL, 1, 4);
    cyc("imiss2", STL, 2, 4);
    idle();
    cyc("imiss_end", IDLE, 3, 0);
    cyc("resume_hold", FRZ, 3, 0);
    cyc("resume_done", IDLE, 4, 0);

    // Forwarding
    idle(); rs1_e = 5; rd_m = 5; regwrite_m = 1'b1; rd_w = 5; regwrite_w = 1'b1;
    cyc("fwd_m_over_w", FWA_M, 4, 0);
    idle(); rs2_e = 7; rd_w = 7; regwrite_w = 1'b1; rd_m = 7; regwrite_m = 1'b0;
    cyc("fwd_w", FWB_W, -1, 0);
    idle(); regwrite_m = 1'b1; regwrite_w = 1'b1;
    cyc("fwd_x0", IDLE, -1, 0);

    // RAW without forwarding (B only stalls)
    idle(); rs1_d = 4; rd_e = 4; regwrite_e = 1'b1;
    cyc("raw_e", IDLE, -1, 4);
    idle(); rs2_d = 6; rd_m = 6; regwrite_m = 1'b1;
    cyc("raw_m", IDLE, -1, 4);

    // Load-use, LOAD_LAT=2 on A
    idle(); load_e = 1'b1; rd_e = 3; regwrite_e = 1'b1; rs2_d = 3;
    cyc("lu_detect", STL, 4, 4);
    idle(); rs2_d = 3; rd_m = 3; regwrite_m = 1'b1;
    cyc("lu_hold", STL, 5, 4);
    idle(); rs2_d = 3; rd_w = 3; regwrite_w = 1'b1;
    cyc("lu_release", IDLE, 6, 0);

    // Mispredict coincident with load-use detect
    idle(); load_e = 1'b1; rd_e = 3; regwrite_e = 1'b1; rs1_d = 3; mispredict = 1'b1;
    cyc("msp_lu", MSP, 6, 0);
    idle();
    cyc("msp_lu_next", IDLE, 6, 0);

    // Mispredict with an I-miss keeps the PC held
    idle(); mispredict = 1'b1; imem_ready = 1'b0;
    cyc("msp_imiss", MSPI, 6, 4);
    idle();
    cyc("msp_imiss_end", IDLE, 7, 0);
    cyc("msp_resume", FRZ, 7, 0);
    cyc("msp_resume_done", IDLE, 8, 0);

    // D-miss for 4 cycles; a mispredict inside the freeze is ignored
    for (int i = 0; i < 4; i++) begin
      idle(); dmem_ready = 1'b0;
      if (i == 1) mispredict = 1'b1;
      cyc("dmiss", FRZ, 8 + i, 4);
    end
    idle();
    cyc("dmiss_end", IDLE, 12, 0);
    cyc("dmiss_hold", FRZ, 12, 0);
    cyc("dmiss_done", IDLE, 13, 0);

    // Counter saturation at 15
    for (int i = 0; i < 20; i++) begin
      idle(); imem_ready = 1'b0;
      cyc("sat", STL, (13 + i > 15) ? 15 : 13 + i, 4);
    end
    idle();
    cyc("sat_end", IDLE, 15, 0);
    cyc("sat_hold", FRZ, 15, 0);
    cyc("sat_idle", IDLE, 15, 0);

    // Reset overrides freeze and forwarding, clears counter and miss tracking
    idle(); reset = 1'b1; dmem_ready = 1'b0; rs1_e = 5; rd_m = 5; regwrite_m = 1'b1;
    cyc("rst_over", RST, 15, 0);
    cyc("rst_clear", RST, 0, 0);
    idle();
    cyc("post_rst", IDLE, 0, 0);
    cyc("post_rst2", IDLE, 0, 0);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
